fpu_addsub_param: RTL and testbench
===================================

Name: fpu_addsub_param

Overview:
- Parametrised, multi-cycle floating-point adder/subtractor for the team's custom float format: {sign, EXP_W exponent, MANT_W fraction}, hidden leading 1, bias 2^(EXP_W-1)-1.
- Generalises the fixed 32-bit free-running adder in three ways: configurable widths, a start/done handshake, and an add/subtract mode.
- Rounding is round-to-nearest-even using guard/round/sticky bits.
- Sits between the operand register file and the result/status capture logic.

Parameters:
EXP_W, 6, exponent width in bits
MANT_W, 25, stored fraction width in bits (hidden bit excluded)
W, 1+EXP_W+MANT_W (derived, default 32), total operand width

Ports:
clock100KHz  in   1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle request; sampled only in IDLE
op_sub  in  1  0 = A+B, 1 = A-B (B sign inverted); latched with the operands
op_A_in  in  W  operand A; latched when start is accepted
op_B_in  in  W  operand B; latched when start is accepted
busy  out  1  high from the accept edge until the edge that asserts done
done  out  1  one-cycle pulse; data_out and status_out are valid while it is high
data_out  out  W  result; holds its value until the next done
status_out  out  4  one-hot status: 0001 EXACT, 0010 INEXACT, 0100 OVERFLOW, 1000 UNDERFLOW; holds until the next done

Behaviour:
- Reset (asynchronous, active-low): state=IDLE, busy=0, done=0, data_out=0, status_out=0000, all internal registers cleared. Asserting reset mid-operation aborts the operation; no done is produced.
- Operand decode: exponent 0 means the operand is zero (hidden bit 0, fraction ignored). The all-ones exponent is not a legal input; behaviour for it is undefined.
- Internal mantissa layout: {carry, hidden, MANT_W fraction, guard, round, sticky}.
- IDLE: done=0. If start=1, latch the operands and op_sub, set busy=1, go to ALIGN. A start pulse outside IDLE is ignored.
- ALIGN (1 cycle):
  - Swap operands so the larger-exponent operand comes first; result exponent = larger exponent.
  - Right-shift the smaller mantissa by the exponent difference in a single step (barrel shift).
  - Any bit shifted past the round position ORs into sticky.
  - If the difference is MANT_W+3 or more, the aligned mantissa is 0 and sticky = (smaller operand nonzero).
- OPERATE (1 cycle):
  - Effective sign = signA XOR signB XOR op_sub.
  - Same effective sign: add magnitudes.
  - Otherwise: subtract the smaller magnitude from the larger; result sign = sign of the larger operand.
  - Equal magnitudes give +0.
- NORMALIZE (1 cycle per shift, plus 1 exit cycle):
  - Mantissa == 0: result is +0, go to ROUND.
  - Carry set: shift right 1 (LSB ORs into sticky), exponent+1.
  - Hidden bit clear: shift left 1, exponent-1. If the exponent is already 1, underflow; go to ROUND.
  - Otherwise go to ROUND.
  - Exponent reaching all-ones sets overflow.
- ROUND (1 cycle):
  - Increment when guard & (round | sticky | LSB).
  - If the increment carries out of the hidden bit: fraction=0, exponent+1, then re-check overflow.
  - inexact = guard | round | sticky.
- Output: registered at the edge leaving ROUND, together with done=1 and busy=0; the next state is IDLE. Status priority:
  - Overflow: data_out={sign, all-ones exponent, 0}, status 0100.
  - Underflow: data_out=0, status 1000.
  - Zero: data_out=0, status 0001.
  - Otherwise: normal result; status 0010 if inexact, else 0001.
- Latency: done is high in the cycle after edge N+4+s, where N is the accept edge and s is the number of normalize shifts (0..MANT_W+2).
- Back-to-back operation: the earliest a new start can be accepted is the cycle in which done is high. Because the FSM is in IDLE during that cycle, that start is accepted.

Test Plan (defaults EXP_W=6, MANT_W=25, bias 31):
- 1.0+1.0: A=B=0x3E000000, op_sub=0 -> data_out=0x40000000, status 0001, done 5 cycles after the accept edge (s=1); busy high throughout.
- 1.0-1.0: A=B=0x3E000000, op_sub=1 -> data_out=0x00000000, status 0001, latency 4 cycles.
- Tie rounding: A=0x3E000000, B=0x0A000000 (2^-26), op_sub=0 -> rounds to even, data_out=0x3E000000, status 0010.
- Overflow: A=B=0x7DFFFFFF, op_sub=0 -> data_out=0x7E000000, status 0100.
- Underflow: A=0x03000000, B=0x02000000, op_sub=1 -> data_out=0x00000000, status 1000.
- Control: pulse start while busy -> the pulse is ignored, only one done is produced. Assert reset mid-ALIGN -> done=0, data_out=0, status_out=0000; the next start then completes normally.

Source files
------------

// File: rtl/fpu_addsub_param_if.sv
// Request/response bundle between the operand register file, the adder and the result capture logic.
interface fpu_addsub_param_if #(
  parameter int unsigned W = 32
);
  logic         start;
  logic         op_sub;
  logic [W-1:0] op_A_in;
  logic [W-1:0] op_B_in;
  logic         busy;
  logic         done;
  logic [W-1:0] data_out;
  logic [3:0]   status_out;

  modport master (
    output start, op_sub, op_A_in, op_B_in,
    input  busy, done, data_out, status_out
  );

  modport slave (
    input  start, op_sub, op_A_in, op_B_in,
    output busy, done, data_out, status_out
  );
endinterface

// File: rtl/fpu_addsub_param.sv
// Multi-cycle parametrised float adder/subtractor: align, operate, normalize, round-to-nearest-even.
module fpu_addsub_param #(
  parameter int unsigned EXP_W  = 6,
  parameter int unsigned MANT_W = 25,
  parameter int unsigned W      = 1 + EXP_W + MANT_W
) (
  input  logic              clock100KHz,
  input  logic              reset,
  fpu_addsub_param_if.slave bus
);

  // Mantissa layout: {carry, hidden, fraction, guard, round, sticky}
  localparam int unsigned MW        = MANT_W + 5;
  localparam int unsigned XW        = EXP_W + 1;
  localparam int unsigned RW        = MANT_W + 1;
  localparam int unsigned FAR_SHIFT = MANT_W + 3;

  localparam logic [XW-1:0] EXP_MAX    = {1'b0, {EXP_W{1'b1}}};
  localparam logic [3:0]    ST_EXACT   = 4'b0001;
  localparam logic [3:0]    ST_INEXACT = 4'b0010;
  localparam logic [3:0]    ST_OVF     = 4'b0100;
  localparam logic [3:0]    ST_UNF     = 4'b1000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_OPERATE,
    S_NORM,
    S_ROUND
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [W-1:0]    r_a, w_a_nxt;
  logic [W-1:0]    r_b, w_b_nxt;
  logic            r_sub, w_sub_nxt;
  logic [MW-1:0]   r_mx, w_mx_nxt;
  logic [MW-1:0]   r_my, w_my_nxt;
  logic            r_sx, w_sx_nxt;
  logic            r_sy, w_sy_nxt;
  logic [MW-1:0]   r_mant, w_mant_nxt;
  logic            r_sign, w_sign_nxt;
  logic [XW-1:0]   r_exp, w_exp_nxt;
  logic            r_ovf, w_ovf_nxt;
  logic            r_unf, w_unf_nxt;
  logic            r_zero, w_zero_nxt;
  logic            r_busy, w_busy_nxt;
  logic            r_done, w_done_nxt;
  logic [W-1:0]    r_data, w_data_nxt;
  logic [3:0]      r_status, w_status_nxt;

  // Operand decode and alignment of the smaller-exponent operand
  logic [EXP_W-1:0] w_ea, w_eb, w_e_big, w_e_small, w_diff;
  logic [MW-1:0]    w_ma, w_mb, w_m_big, w_m_small, w_shifted, w_mask, w_aligned;
  logic             w_sa, w_sb, w_swap, w_s_big, w_s_small, w_far, w_sticky;

  assign w_ea      = r_a[W-2 -: EXP_W];
  assign w_eb      = r_b[W-2 -: EXP_W];
  assign w_sa      = r_a[W-1];
  assign w_sb      = r_b[W-1] ^ r_sub;
  assign w_ma      = (w_ea == '0) ? '0 : {2'b01, r_a[MANT_W-1:0], 3'b000};
  assign w_mb      = (w_eb == '0) ? '0 : {2'b01, r_b[MANT_W-1:0], 3'b000};
  assign w_swap    = (w_eb > w_ea);
  assign w_e_big   = w_swap ? w_eb : w_ea;
  assign w_e_small = w_swap ? w_ea : w_eb;
  assign w_m_big   = w_swap ? w_mb : w_ma;
  assign w_m_small = w_swap ? w_ma : w_mb;
  assign w_s_big   = w_swap ? w_sb : w_sa;
  assign w_s_small = w_swap ? w_sa : w_sb;
  assign w_diff    = w_e_big - w_e_small;
  assign w_far     = (32'(w_diff) >= FAR_SHIFT);
  assign w_shifted = w_m_small >> w_diff;
  // Every source bit that lands at or below the sticky position is folded into sticky
  assign w_mask    = (MW'(1) << (w_diff + EXP_W'(1))) - MW'(1);
  assign w_sticky  = |(w_m_small & w_mask);
  assign w_aligned = w_far ? {{(MW-1){1'b0}}, |w_m_small}
                           : (w_shifted | {{(MW-1){1'b0}}, w_sticky});

  // Round-to-nearest-even on the normalized mantissa
  logic          w_lsb, w_guard, w_round, w_stk, w_inc, w_inexact, w_rcarry, w_rovf;
  logic [RW-1:0] w_rsum;
  logic [XW-1:0] w_rexp;

  assign w_lsb     = r_mant[3];
  assign w_guard   = r_mant[2];
  assign w_round   = r_mant[1];
  assign w_stk     = r_mant[0];
  assign w_inc     = w_guard & (w_round | w_stk | w_lsb);
  assign w_inexact = w_guard | w_round | w_stk;
  assign w_rsum    = {1'b0, r_mant[MW-3:3]} + RW'(w_inc);
  assign w_rcarry  = w_rsum[MANT_W];
  assign w_rexp    = r_exp + XW'(w_rcarry);
  assign w_rovf    = r_ovf | (w_rexp >= EXP_MAX);

  always_ff @(posedge clock100KHz or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_sub    <= 1'b0;
      r_mx     <= '0;
      r_my     <= '0;
      r_sx     <= 1'b0;
      r_sy     <= 1'b0;
      r_mant   <= '0;
      r_sign   <= 1'b0;
      r_exp    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_data   <= '0;
      r_status <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_sub    <= w_sub_nxt;
      r_mx     <= w_mx_nxt;
      r_my     <= w_my_nxt;
      r_sx     <= w_sx_nxt;
      r_sy     <= w_sy_nxt;
      r_mant   <= w_mant_nxt;
      r_sign   <= w_sign_nxt;
      r_exp    <= w_exp_nxt;
      r_ovf    <= w_ovf_nxt;
      r_unf    <= w_unf_nxt;
      r_zero   <= w_zero_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_data   <= w_data_nxt;
      r_status <= w_status_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_sub_nxt    = r_sub;
    w_mx_nxt     = r_mx;
    w_my_nxt     = r_my;
    w_sx_nxt     = r_sx;
    w_sy_nxt     = r_sy;
    w_mant_nxt   = r_mant;
    w_sign_nxt   = r_sign;
    w_exp_nxt    = r_exp;
    w_ovf_nxt    = r_ovf;
    w_unf_nxt    = r_unf;
    w_zero_nxt   = r_zero;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_data_nxt   = r_data;
    w_status_nxt = r_status;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_a_nxt     = bus.op_A_in;
          w_b_nxt     = bus.op_B_in;
          w_sub_nxt   = bus.op_sub;
          w_ovf_nxt   = 1'b0;
          w_unf_nxt   = 1'b0;
          w_zero_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_ALIGN;
        end
      end

      S_ALIGN: begin
        w_mx_nxt    = w_m_big;
        w_my_nxt    = w_aligned;
        w_sx_nxt    = w_s_big;
        w_sy_nxt    = w_s_small;
        w_exp_nxt   = {1'b0, w_e_big};
        w_state_nxt = S_OPERATE;
      end

      S_OPERATE: begin
        if (r_sx == r_sy) begin
          w_mant_nxt = r_mx + r_my;
          w_sign_nxt = r_sx;
        end else if (r_mx > r_my) begin
          w_mant_nxt = r_mx - r_my;
          w_sign_nxt = r_sx;
        end else if (r_my > r_mx) begin
          w_mant_nxt = r_my - r_mx;
          w_sign_nxt = r_sy;
        end else begin
          w_mant_nxt = '0;
          w_sign_nxt = 1'b0;
        end
        w_state_nxt = S_NORM;
      end

      S_NORM: begin
        if (r_mant == '0) begin
          w_zero_nxt  = 1'b1;
          w_sign_nxt  = 1'b0;
          w_state_nxt = S_ROUND;
        end else if (r_mant[MW-1]) begin
          w_mant_nxt = {1'b0, r_mant[MW-1:2], r_mant[1] | r_mant[0]};
          w_exp_nxt  = r_exp + XW'(1);
          if (r_exp + XW'(1) >= EXP_MAX) w_ovf_nxt = 1'b1;
        end else if (!r_mant[MW-2]) begin
          if (r_exp <= XW'(1)) begin
            w_unf_nxt   = 1'b1;
            w_state_nxt = S_ROUND;
          end else begin
            w_mant_nxt = r_mant << 1;
            w_exp_nxt  = r_exp - XW'(1);
          end
        end else begin
          w_state_nxt = S_ROUND;
        end
      end

      S_ROUND: begin
        w_state_nxt = S_IDLE;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        if (w_rovf) begin
          w_data_nxt   = {r_sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          w_status_nxt = ST_OVF;
        end else if (r_unf) begin
          w_data_nxt   = '0;
          w_status_nxt = ST_UNF;
        end else if (r_zero) begin
          w_data_nxt   = '0;
          w_status_nxt = ST_EXACT;
        end else begin
          w_data_nxt   = {r_sign, w_rexp[EXP_W-1:0], w_rsum[MANT_W-1:0]};
          w_status_nxt = w_inexact ? ST_INEXACT : ST_EXACT;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.data_out   = r_data;
  assign bus.status_out = r_status;

endmodule

// File: tb/tb_fpu_addsub_param.sv
// Bench for fpu_addsub_param: directed vector table, control sequences, and random ops against an exact-arithmetic model.
module tb_fpu_addsub_param;

  localparam int EW   = 6;
  localparam int FW   = 25;
  localparam int BW   = 1 + EW + FW;
  localparam int EMAX = (1 << EW) - 1;
  localparam int NV   = 9;

  typedef struct {
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          sub;
    logic [BW-1:0] d;
    logic [3:0]    st;
    int            lat;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs [NV];

  fpu_addsub_param_if #(.W(BW)) bus ();

  fpu_addsub_param #(.EXP_W(EW), .MANT_W(FW)) dut (
    .clock100KHz (clk),
    .reset       (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Exact sum on wide integers, then normalize and round to nearest even
  function automatic void ref_model(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                                    output logic [BW-1:0] d, output logic [3:0] st);
    logic [127:0] va, vb, mag, keep, rem, half;
    int  ea, eb, emin, p, sh, e;
    logic sa, sb, sgn;
    bit  inexact;
    ea = int'(a[BW-2 -: EW]);
    eb = int'(b[BW-2 -: EW]);
    sa = a[BW-1];
    sb = b[BW-1] ^ sub;
    d  = '0;
    st = 4'b0001;
    if (ea == 0 && eb == 0) return;
    if (ea == 0) emin = eb;
    else if (eb == 0) emin = ea;
    else emin = (ea < eb) ? ea : eb;
    va = (ea == 0) ? 128'd0 : ((128'(a[FW-1:0]) | (128'd1 << FW)) << (ea - emin));
    vb = (eb == 0) ? 128'd0 : ((128'(b[FW-1:0]) | (128'd1 << FW)) << (eb - emin));
    if (sa == sb) begin
      mag = va + vb; sgn = sa;
    end else if (va > vb) begin
      mag = va - vb; sgn = sa;
    end else begin
      mag = vb - va; sgn = sb;
    end
    if (mag == 128'd0) return;
    p = 0;
    for (int i = 0; i < 128; i++) if (mag[i]) p = i;
    e = emin + p - FW;
    if (p > FW) begin
      sh   = p - FW;
      keep = mag >> sh;
      rem  = mag & ((128'd1 << sh) - 128'd1);
      half = 128'd1 << (sh - 1);
      inexact = (rem != 128'd0);
      if (rem > half || (rem == half && keep[0])) keep = keep + 128'd1;
    end else begin
      keep = mag << (FW - p);
      inexact = 1'b0;
    end
    if (keep[FW+1]) begin
      keep = keep >> 1;
      e = e + 1;
    end
    if (e >= EMAX) begin
      d = {sgn, EW'(EMAX), FW'(0)}; st = 4'b0100;
    end else if (e < 1) begin
      d = '0; st = 4'b1000;
    end else begin
      d = {sgn, EW'(e), keep[FW-1:0]}; st = inexact ? 4'b0010 : 4'b0001;
    end
  endfunction

  // Called at a falling edge; returns at the falling edge where done is seen (or after the budget).
  task automatic run_op(input logic [BW-1:0] a, input logic [BW-1:0] b, input logic sub,
                        output logic [BW-1:0] d, output logic [3:0] st, output int lat, output bit busy_ok);
    bus.start   = 1'b1;
    bus.op_A_in = a;
    bus.op_B_in = b;
    bus.op_sub  = sub;
    @(negedge clk);
    bus.start = 1'b0;
    busy_ok = (bus.busy === 1'b1);
    lat = -1;
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = k;
        if (bus.busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (bus.busy !== 1'b1) busy_ok = 1'b0;
    end
    d  = bus.data_out;
    st = bus.status_out;
  endtask

  initial begin
    logic [BW-1:0] d, a, b, ed;
    logic [3:0]    st, est;
    logic          sub;
    int            lat, dones, ea, eb;
    bit            bok;

    vecs[0] = '{32'h3E000000, 32'h3E000000, 1'b0, 32'h40000000, 4'b0001, 5};
    vecs[1] = '{32'h3E000000, 32'h3E000000, 1'b1, 32'h00000000, 4'b0001, 4};
    vecs[2] = '{32'h3E000000, 32'h0A000000, 1'b0, 32'h3E000000, 4'b0010, 4};
    vecs[3] = '{32'h7DFFFFFF, 32'h7DFFFFFF, 1'b0, 32'h7E000000, 4'b0100, 5};
    vecs[4] = '{32'h03000000, 32'h02000000, 1'b1, 32'h00000000, 4'b1000, 4};
    vecs[5] = '{32'h3E000001, 32'h0A000000, 1'b0, 32'h3E000002, 4'b0010, 4};
    vecs[6] = '{32'h40000000, 32'h3E000000, 1'b1, 32'h3E000000, 4'b0001, 5};
    vecs[7] = '{32'hBE000000, 32'hBE000000, 1'b0, 32'hC0000000, 4'b0001, 5};
    vecs[8] = '{32'h00000000, 32'h3E000000, 1'b1, 32'hBE000000, 4'b0001, 4};

    bus.start   = 1'b0;
    bus.op_sub  = 1'b0;
    bus.op_A_in = '0;
    bus.op_B_in = '0;

    repeat (3) @(negedge clk);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset done", 32'(bus.done), 32'd0);
    chk("reset data", bus.data_out, 32'd0);
    chk("reset status", 32'(bus.status_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table, issued back-to-back (each start lands in the previous done cycle)
    for (int i = 0; i < NV; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, d, st, lat, bok);
      chk($sformatf("vec%0d data", i), d, vecs[i].d);
      chk($sformatf("vec%0d status", i), 32'(st), 32'(vecs[i].st));
      chk($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("vec%0d busy", i), 32'(bok), 32'd1);
    end

    repeat (3) @(negedge clk);
    chk("hold data", bus.data_out, vecs[NV-1].d);
    chk("hold done low", 32'(bus.done), 32'd0);

    // Start pulse while busy must be ignored
    bus.start = 1'b1; bus.op_A_in = 32'h3E000000; bus.op_B_in = 32'h3E000000; bus.op_sub = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.op_A_in = 32'h40000000; bus.op_B_in = 32'h40000000;
    @(negedge clk); bus.start = 1'b0;
    dones = 0;
    d = '0;
    for (int k = 0; k < 30; k++) begin
      if (bus.done === 1'b1) begin
        dones++;
        d = bus.data_out;
      end
      @(negedge clk);
    end
    chk("ignored start done count", 32'(dones), 32'd1);
    chk("ignored start data", d, 32'h40000000);

    // Reset while in ALIGN aborts the operation
    bus.start = 1'b1; bus.op_A_in = 32'h3E000000; bus.op_B_in = 32'h3E000000; bus.op_sub = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("abort done", 32'(bus.done), 32'd0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort data", bus.data_out, 32'd0);
    chk("abort status", 32'(bus.status_out), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (bus.done === 1'b1) dones++;
    end
    chk("abort no done", 32'(dones), 32'd0);
    run_op(32'h3E000000, 32'h40000000, 1'b0, d, st, lat, bok);
    chk("post-abort data", d, 32'h41000000);
    chk("post-abort status", 32'(st), 32'b0001);
    chk("post-abort latency", 32'(lat), 32'd4);

    // Random operations against the exact model
    for (int i = 0; i < 300; i++) begin
      ea = ($urandom_range(15) == 0) ? 0 : int'($urandom_range(62, 1));
      if ($urandom_range(1) == 1) eb = ea + int'($urandom_range(6)) - 3;
      else eb = int'($urandom_range(62, 0));
      if (eb < 0) eb = 0;
      if (eb > 62) eb = 62;
      a   = {1'($urandom_range(1)), EW'(ea), FW'($urandom)};
      b   = {1'($urandom_range(1)), EW'(eb), FW'($urandom)};
      sub = 1'($urandom_range(1));
      ref_model(a, b, sub, ed, est);
      run_op(a, b, sub, d, st, lat, bok);
      chk($sformatf("rand%0d data a=%h b=%h sub=%0d", i, a, b, sub), d, ed);
      chk($sformatf("rand%0d status a=%h b=%h sub=%0d", i, a, b, sub), 32'(st), 32'(est));
      chk($sformatf("rand%0d latency in range", i), 32'(lat >= 4 && lat <= FW + 6), 32'd1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
